// File: rtl/cdc_hs_rx.sv
// Destination-side receive stage of a 4-phase req/ack crossing: captures the
// quasi-static source bus on a synchronised request and returns an ack level.
//
// state | meaning
// IDLE  | waiting for req_d; dout holds the last captured word
// VALID | dout_vld high, waiting for consumer dout_rdy
// ACK   | ack_d high, waiting for req_d to drop; timeout counter running
module cdc_hs_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TMO_CYCLES = 1024
) (
  input  logic                  clk_d,
  input  logic                  rstn_d,
  input  logic                  req_d,
  input  logic [DATA_WIDTH-1:0] data_s,
  output logic                  ack_d,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  err
);

  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_vld;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_err;
  logic [TW-1:0]         r_tmo;

  always_ff @(posedge clk_d or negedge rstn_d) begin
    if (!rstn_d) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_d) begin
            r_dout  <= data_s;
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= VALID;
          end
        end
        VALID: begin
          // Early req drop is flagged but the captured word is still delivered.
          if (!req_d) r_err <= 1'b1;
          if (r_vld && dout_rdy) begin
            r_vld   <= 1'b0;
            r_ack   <= 1'b1;
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
            r_tmo   <= '0;
            r_state <= ACK;
          end
        end
        ACK: begin
          if (!req_d) begin
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_tmo == TMO_LAST) begin
            // Saturate and stay in ACK; recovery is left to the source or reset.
            r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_d    = r_ack;
  assign dout     = r_dout;
  assign dout_vld = r_vld;
  assign busy     = r_busy;
  assign xfer_cnt = r_cnt;
  assign err      = r_err;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Directed bench for cdc_hs_rx with a narrow counter and short timeout so that
// wrap and timeout are reachable in a few hundred cycles.
module tb_cdc_hs_rx;

  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int TMO = 8;

  logic          clk_d = 1'b0;
  logic          rstn_d;
  logic          req_d;
  logic [DW-1:0] data_s;
  logic          ack_d;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic          busy;
  logic [CW-1:0] xfer_cnt;
  logic          err;

  int total = 0;
  int bad   = 0;

  cdc_hs_rx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TMO_CYCLES(TMO)) dut (
    .clk_d    (clk_d),
    .rstn_d   (rstn_d),
    .req_d    (req_d),
    .data_s   (data_s),
    .ack_d    (ack_d),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .busy     (busy),
    .xfer_cnt (xfer_cnt),
    .err      (err)
  );

  always #5 clk_d = ~clk_d;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_d);
    #1;
  endtask

  task automatic do_reset();
    rstn_d = 1'b0;
    req_d = 1'b0;
    dout_rdy = 1'b0;
    data_s = '0;
    tick();
    tick();
    @(negedge clk_d);
    rstn_d = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ack_d, dout_vld, busy, err} !== 4'b0000 || dout !== '0 || xfer_cnt !== '0) begin
      bad++;
      $display("FAIL reset: ack=%b vld=%b busy=%b err=%b dout=%h cnt=%0d, want all zero",
               ack_d, dout_vld, busy, err, dout, xfer_cnt);
    end
  endtask

  task automatic test_basic();
    data_s = 32'hDEADBEEF;
    req_d = 1'b1;
    dout_rdy = 1'b1;
    tick();
    total++;
    if (dout_vld !== 1'b1 || dout !== 32'hDEADBEEF || ack_d !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_capture: vld=%b dout=%h ack=%b busy=%b, want 1 deadbeef 0 1",
               dout_vld, dout, ack_d, busy);
    end
    tick();
    total++;
    if (ack_d !== 1'b1 || dout_vld !== 1'b0 || xfer_cnt !== 4'd1 || dout !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_ack: ack=%b vld=%b cnt=%0d dout=%h, want 1 0 1 deadbeef",
               ack_d, dout_vld, xfer_cnt, dout);
    end
    req_d = 1'b0;
    tick();
    total++;
    if (ack_d !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL basic_release: ack=%b busy=%b err=%b, want 0 0 0", ack_d, busy, err);
    end
  endtask

  task automatic test_backpressure();
    data_s = 32'h12345678;
    dout_rdy = 1'b0;
    req_d = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      dout_rdy = 1'b0;
      tick();
      total++;
      if (dout_vld !== 1'b1 || dout !== 32'h12345678 || ack_d !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold[%0d]: vld=%b dout=%h ack=%b, want 1 12345678 0",
                 i, dout_vld, dout, ack_d);
      end
    end
    dout_rdy = 1'b1;
    tick();
    total++;
    if (ack_d !== 1'b1 || dout_vld !== 1'b0 || xfer_cnt !== 4'd2) begin
      bad++;
      $display("FAIL backpressure_release: ack=%b vld=%b cnt=%0d, want 1 0 2",
               ack_d, dout_vld, xfer_cnt);
    end
    req_d = 1'b0;
    tick();
  endtask

  task automatic test_counter_wrap();
    logic [CW-1:0] exp_cnt;
    logic          saw_15;
    do_reset();
    exp_cnt = '0;
    saw_15 = 1'b0;
    dout_rdy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_s = 32'hA000_0000 + i;
      req_d = 1'b1;
      tick();
      tick();
      exp_cnt = exp_cnt + 4'd1;
      if (xfer_cnt === 4'd15) saw_15 = 1'b1;
      total++;
      if (xfer_cnt !== exp_cnt || err !== 1'b0 || ack_d !== 1'b1) begin
        bad++;
        $display("FAIL wrap[%0d]: cnt=%0d err=%b ack=%b, want %0d 0 1",
                 i, xfer_cnt, err, ack_d, exp_cnt);
      end
      req_d = 1'b0;
      tick();
    end
    total++;
    if (xfer_cnt !== 4'd1 || !saw_15) begin
      bad++;
      $display("FAIL wrap_end: cnt=%0d saw15=%b, want 1 1", xfer_cnt, saw_15);
    end
  endtask

  task automatic test_timeout();
    data_s = 32'h0BAD_F00D;
    req_d = 1'b1;
    dout_rdy = 1'b1;
    tick();
    tick();
    total++;
    if (ack_d !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_ack: ack=%b err=%b, want 1 0", ack_d, err);
    end
    for (int k = 1; k <= TMO; k++) begin
      tick();
      total++;
      if (err !== (k == TMO) || ack_d !== 1'b1) begin
        bad++;
        $display("FAIL timeout_cycle[%0d]: err=%b ack=%b, want %b 1", k, err, ack_d, k == TMO);
      end
    end
    tick();
    tick();
    total++;
    if (err !== 1'b1 || ack_d !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_hold: err=%b ack=%b busy=%b, want 1 1 1", err, ack_d, busy);
    end
    req_d = 1'b0;
    tick();
    total++;
    if (ack_d !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_exit: ack=%b busy=%b err=%b, want 0 0 1", ack_d, busy, err);
    end
  endtask

  task automatic test_protocol_violation();
    do_reset();
    data_s = 32'hCAFE_0001;
    dout_rdy = 1'b0;
    req_d = 1'b1;
    tick();
    req_d = 1'b0;
    tick();
    total++;
    if (err !== 1'b1 || dout_vld !== 1'b1 || ack_d !== 1'b0) begin
      bad++;
      $display("FAIL proto_flag: err=%b vld=%b ack=%b, want 1 1 0", err, dout_vld, ack_d);
    end
    dout_rdy = 1'b1;
    tick();
    total++;
    if (ack_d !== 1'b1 || xfer_cnt !== 4'd1 || dout !== 32'hCAFE_0001) begin
      bad++;
      $display("FAIL proto_complete: ack=%b cnt=%0d dout=%h, want 1 1 cafe0001",
               ack_d, xfer_cnt, dout);
    end
    tick();
    total++;
    if (ack_d !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL proto_exit: ack=%b busy=%b err=%b, want 0 0 1", ack_d, busy, err);
    end
  endtask

  task automatic test_reset_mid_transfer();
    data_s = 32'h5555_AAAA;
    dout_rdy = 1'b1;
    req_d = 1'b1;
    tick();
    tick();
    total++;
    if (ack_d !== 1'b1 || xfer_cnt !== 4'd2) begin
      bad++;
      $display("FAIL midrst_pre: ack=%b cnt=%0d, want 1 2", ack_d, xfer_cnt);
    end
    rstn_d = 1'b0;
    #1;
    total++;
    if (ack_d !== 1'b0 || dout_vld !== 1'b0 || xfer_cnt !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: ack=%b vld=%b cnt=%0d busy=%b err=%b, want all 0",
               ack_d, dout_vld, xfer_cnt, busy, err);
    end
    tick();
    @(negedge clk_d);
    data_s = 32'h7777_1111;
    rstn_d = 1'b1;
    #1;
    total++;
    if (dout_vld !== 1'b0 || dout !== '0) begin
      bad++;
      $display("FAIL midrst_release: vld=%b dout=%h, want 0 0", dout_vld, dout);
    end
    tick();
    total++;
    if (dout_vld !== 1'b1 || dout !== 32'h7777_1111 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_recapture: vld=%b dout=%h busy=%b, want 1 77771111 1",
               dout_vld, dout, busy);
    end
    req_d = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_counter_wrap();
    test_timeout();
    test_protocol_violation();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
